// File: rtl/block_packer_pkg.sv
// Shared types and helpers for the block packer: FSM encoding, block geometry
// and s_keep decoding.
package block_packer_pkg;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT     = 2'd1,
    EMIT_PAD = 2'd2
  } packer_state_e;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [7:0] PAD_BYTE    = 8'h01;

  function automatic logic [2:0] keep_popcount(input logic [3:0] keep);
    keep_popcount = {2'b00, keep[0]} + {2'b00, keep[1]} +
                    {2'b00, keep[2]} + {2'b00, keep[3]};
  endfunction

  function automatic logic keep_legal(input logic [3:0] keep);
    case (keep)
      4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: keep_legal = 1'b1;
      default:                                     keep_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/block_packer_if.sv
// Word-stream input and block output handshakes of the block packer.
// slave: the packer's view; master: the environment driving words and taking blocks.
interface block_packer_if;
  logic [31:0]  s_data;
  logic [3:0]   s_keep;
  logic         s_last;
  logic         s_type;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] m_block;
  logic         m_type;
  logic         m_last;
  logic [4:0]   m_nbytes;
  logic         m_valid;
  logic         m_ready;

  modport slave (
    input  s_data, s_keep, s_last, s_type, s_valid, m_ready,
    output s_ready, m_block, m_type, m_last, m_nbytes, m_valid
  );

  modport master (
    output s_data, s_keep, s_last, s_type, s_valid, m_ready,
    input  s_ready, m_block, m_type, m_last, m_nbytes, m_valid
  );
endinterface

// File: rtl/block_packer_pad.sv
// Combinational padder: raw byte vector (byte j at bits 8j+7:8j) to core block
// layout, inserting PAD_BYTE after the last message byte when requested.
module block_pad
  import block_packer_pkg::*;
(
  input  logic [127:0] i_raw,
  input  logic [4:0]   i_nbytes,
  input  logic         i_pad_en,
  output logic [127:0] o_block
);

  logic [7:0] w_byte;

  // Byte j of the block lands in the upper half for j < 8, lower half otherwise.
  always_comb begin
    o_block = '0;
    w_byte  = 8'h00;
    for (int j = 0; j < BLOCK_BYTES; j++) begin
      if (5'(j) < i_nbytes) begin
        w_byte = i_raw[8*j +: 8];
      end else if (i_pad_en && (5'(j) == i_nbytes)) begin
        w_byte = PAD_BYTE;
      end else begin
        w_byte = 8'h00;
      end
      if (j < 8) begin
        o_block[64 + 8*j +: 8] = w_byte;
      end else begin
        o_block[8*(j-8) +: 8] = w_byte;
      end
    end
  end

endmodule

// File: rtl/block_packer.sv
// Packs a 32-bit byte stream into padded 128-bit blocks, adding a pad-only block
// when a message ends exactly on a block boundary.
module block_packer
  import block_packer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  block_packer_if.slave bus,
  output logic          err
);

  packer_state_e r_state;
  logic [1:0]    r_word_cnt;
  logic [127:0]  r_acc;
  logic [4:0]    r_nbytes;
  logic          r_type;
  logic          r_pad_pend;
  logic          r_err;
  logic [127:0]  r_m_block;
  logic          r_m_type;
  logic          r_m_last;
  logic [4:0]    r_m_nbytes;

  logic [2:0]    w_cnt;
  logic [127:0]  w_acc_next;
  logic [4:0]    w_nbytes_next;
  logic          w_word_end;
  logic          w_full;
  logic          w_type_next;
  logic          w_bad_keep;
  logic [127:0]  w_pad_raw;
  logic [4:0]    w_pad_nbytes;
  logic          w_pad_en;
  logic [127:0]  w_padded;

  assign w_cnt         = keep_popcount(bus.s_keep);
  assign w_nbytes_next = r_nbytes + {2'b00, w_cnt};
  assign w_word_end    = bus.s_last || (r_word_cnt == 2'd3);
  assign w_full        = (w_nbytes_next == 5'(BLOCK_BYTES));
  assign w_type_next   = (r_word_cnt == 2'd0) ? bus.s_type : r_type;
  assign w_bad_keep    = !keep_legal(bus.s_keep) ||
                         ((bus.s_keep != 4'b1111) && !bus.s_last);

  // Append the low popcount(s_keep) bytes of the word at byte offset 4*word_cnt.
  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < 4; k++) begin
      w_acc_next[32*int'(r_word_cnt) + 8*k +: 8] =
        (k < int'(w_cnt)) ? bus.s_data[8*k +: 8] : r_acc[32*int'(r_word_cnt) + 8*k +: 8];
    end
  end

  // In EMIT the padder builds the pad-only block; in FILL it builds the data block.
  always_comb begin
    if (r_state == EMIT) begin
      w_pad_raw    = '0;
      w_pad_nbytes = 5'd0;
      w_pad_en     = 1'b1;
    end else begin
      w_pad_raw    = w_acc_next;
      w_pad_nbytes = w_nbytes_next;
      w_pad_en     = bus.s_last && !w_full;
    end
  end

  block_pad u_pad (
    .i_raw    (w_pad_raw),
    .i_nbytes (w_pad_nbytes),
    .i_pad_en (w_pad_en),
    .o_block  (w_padded)
  );

  // Packer FSM with registered block outputs and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_word_cnt <= 2'd0;
      r_acc      <= '0;
      r_nbytes   <= 5'd0;
      r_type     <= 1'b0;
      r_pad_pend <= 1'b0;
      r_err      <= 1'b0;
      r_m_block  <= '0;
      r_m_type   <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_nbytes <= 5'd0;
    end else begin
      case (r_state)
        FILL: begin
          if (bus.s_valid) begin
            r_err <= r_err | w_bad_keep;
            if (r_word_cnt == 2'd0) begin
              r_type <= bus.s_type;
            end
            if (w_word_end) begin
              r_m_block  <= w_padded;
              r_m_nbytes <= w_nbytes_next;
              r_m_last   <= bus.s_last && !w_full;
              r_m_type   <= w_type_next;
              r_pad_pend <= bus.s_last && w_full;
              r_state    <= EMIT;
            end else begin
              r_acc      <= w_acc_next;
              r_nbytes   <= w_nbytes_next;
              r_word_cnt <= r_word_cnt + 2'd1;
            end
          end
        end
        EMIT: begin
          if (bus.m_ready) begin
            if (r_pad_pend) begin
              r_m_block  <= w_padded;
              r_m_nbytes <= 5'd0;
              r_m_last   <= 1'b1;
              r_pad_pend <= 1'b0;
              r_state    <= EMIT_PAD;
            end else begin
              r_acc      <= '0;
              r_nbytes   <= 5'd0;
              r_word_cnt <= 2'd0;
              r_state    <= FILL;
            end
          end
        end
        EMIT_PAD: begin
          if (bus.m_ready) begin
            r_acc      <= '0;
            r_nbytes   <= 5'd0;
            r_word_cnt <= 2'd0;
            r_state    <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.s_ready  = (r_state == FILL);
  assign bus.m_valid  = (r_state == EMIT) || (r_state == EMIT_PAD);
  assign bus.m_block  = r_m_block;
  assign bus.m_type   = r_m_type;
  assign bus.m_last   = r_m_last;
  assign bus.m_nbytes = r_m_nbytes;
  assign err          = r_err;

endmodule

// File: tb/tb_block_packer.sv
// Self-checking bench for block_packer: directed vector table, hand-written corner
// sequences and randomized traffic against a byte-level reference model.
module tb_block_packer;

  logic clk;
  logic rst_n;
  logic err;

  block_packer_if bus();

  block_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] blk;
    logic [4:0]   n;
    logic         last;
    logic         typ;
  } blk_t;

  blk_t exp_q[$];

  typedef struct {
    logic [31:0]  data;
    logic [3:0]   keep;
    logic         last;
    logic         typ;
    logic         exp_valid;
    logic [127:0] exp_block;
    logic [4:0]   exp_n;
    logic         exp_last;
    logic         exp_type;
    logic         exp_pad;
  } vec_t;

  localparam logic [127:0] PAD_ONLY = 128'h0000000000000001_0000000000000000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: bytes of the block under construction, by block position.
  logic [7:0] m_bytes[16];
  int         m_wc = 0;
  int         m_n  = 0;
  logic       m_type = 1'b0;

  function automatic logic [127:0] layout(input int n, input logic pad);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      if (j < n) b = m_bytes[j];
      else if (pad && j == n) b = 8'h01;
      else b = 8'h00;
      if (j < 8) r[64 + 8*j +: 8] = b;
      else r[8*(j-8) +: 8] = b;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 16; j++) m_bytes[j] = 8'h00;
    m_wc = 0;
    m_n  = 0;
  endtask

  task automatic model_word(input logic [31:0] d, input logic [3:0] k, input logic l, input logic t);
    int cnt;
    cnt = $countones(k);
    if (m_wc == 0) m_type = t;
    for (int i = 0; i < cnt; i++) m_bytes[4*m_wc + i] = d[8*i +: 8];
    m_n += cnt;
    if (l || m_wc == 3) begin
      if (l && m_n == 16) begin
        exp_q.push_back('{layout(16, 1'b0), 5'd16, 1'b0, m_type});
        exp_q.push_back('{PAD_ONLY, 5'd0, 1'b1, m_type});
      end else begin
        exp_q.push_back('{layout(m_n, l), 5'(m_n), l, m_type});
      end
      model_clear();
    end else begin
      m_wc++;
    end
  endtask

  // Block monitor: a transfer happens at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_block", bus.m_block, 128'h0);
      end else begin
        check("m_block", bus.m_block, exp_q[0].blk);
        check("m_nbytes", 128'(bus.m_nbytes), 128'(exp_q[0].n));
        check("m_last", 128'(bus.m_last), 128'(exp_q[0].last));
        check("m_type", 128'(bus.m_type), 128'(exp_q[0].typ));
        void'(exp_q.pop_front());
      end
    end
  end

  logic rnd_bp = 1'b0;

  // Random back-pressure on the block side while rnd_bp is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_bp) bus.m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l, input logic t);
    int n;
    n = 0;
    bus.s_data  = d;
    bus.s_keep  = k;
    bus.s_last  = l;
    bus.s_type  = t;
    bus.s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk);
        break;
      end
      n++;
      if (n > 200) begin
        check("accept_timeout", 128'(n), 128'h0);
        break;
      end
    end
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain", 128'(exp_q.size()), 128'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  vec_t vecs[$];

  initial begin
    logic [3:0] legal[5];
    logic [31:0] d;
    logic [3:0] k;
    logic l;
    legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0011;
    legal[3] = 4'b0111; legal[4] = 4'b1111;

    rst_n = 1'b0;
    bus.s_data = 32'h0; bus.s_keep = 4'h0; bus.s_last = 1'b0;
    bus.s_type = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    model_clear();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 128'(bus.s_ready), 128'h1);
    check("rst_m_valid", 128'(bus.m_valid), 128'h0);
    check("rst_m_block", bus.m_block, 128'h0);
    check("rst_m_nbytes", 128'(bus.m_nbytes), 128'h0);
    check("rst_m_last", 128'(bus.m_last), 128'h0);
    check("rst_m_type", 128'(bus.m_type), 128'h0);
    check("rst_err", 128'(err), 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: data, keep, last, type, exp_valid, block, nbytes, last, type, pad.
    vecs.push_back('{32'h03020100, 4'hF, 1'b0, 1'b0, 1'b0, 128'h0, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h07060504, 4'hF, 1'b0, 1'b0, 1'b0, 128'h0, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h0B0A0908, 4'hF, 1'b0, 1'b0, 1'b0, 128'h0, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h0F0E0D0C, 4'hF, 1'b1, 1'b0, 1'b1,
                     128'h0706050403020100_0F0E0D0C0B0A0908, 5'd16, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'hAABBCCDD, 4'h3, 1'b1, 1'b0, 1'b1,
                     128'h000000000001CCDD_0000000000000000, 5'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 4'h0, 1'b1, 1'b1, 1'b1, PAD_ONLY, 5'd0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{32'h44332211, 4'hF, 1'b0, 1'b1, 1'b0, 128'h0, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00776655, 4'h7, 1'b1, 1'b1, 1'b1,
                     128'h0177665544332211_0000000000000000, 5'd7, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{32'h13121110, 4'hF, 1'b0, 1'b0, 1'b0, 128'h0, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h17161514, 4'hF, 1'b0, 1'b0, 1'b0, 128'h0, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h1B1A1918, 4'hF, 1'b0, 1'b0, 1'b0, 128'h0, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h1F1E1D1C, 4'hF, 1'b0, 1'b0, 1'b1,
                     128'h1716151413121110_1F1E1D1C1B1A1918, 5'd16, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h000000EE, 4'h1, 1'b1, 1'b1, 1'b1,
                     128'h00000000000001EE_0000000000000000, 5'd1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{32'h04030201, 4'hF, 1'b0, 1'b1, 1'b0, 128'h0, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h000000FF, 4'h1, 1'b1, 1'b0, 1'b1,
                     128'h000001FF04030201_0000000000000000, 5'd5, 1'b1, 1'b1, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].exp_valid)
        exp_q.push_back('{vecs[i].exp_block, vecs[i].exp_n, vecs[i].exp_last, vecs[i].exp_type});
      if (vecs[i].exp_pad)
        exp_q.push_back('{PAD_ONLY, 5'd0, 1'b1, vecs[i].exp_type});
      send_word(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].typ);
    end
    drain();
    check("err_after_table", 128'(err), 128'h0);

    // Stall: m_ready low for 10 cycles holds the block and blocks input.
    bus.m_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      d = $urandom;
      model_word(d, 4'hF, 1'(w == 3), 1'b1);
      send_word(d, 4'hF, 1'(w == 3), 1'b1);
    end
    check("latency_m_valid", 128'(bus.m_valid), 128'h1);
    bus.s_data = 32'hDEADBEEF; bus.s_keep = 4'hF; bus.s_last = 1'b1; bus.s_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("stall_s_ready", 128'(bus.s_ready), 128'h0);
      check("stall_m_valid", 128'(bus.m_valid), 128'h1);
      check("stall_m_block", bus.m_block, exp_q[0].blk);
      check("stall_m_nbytes", 128'(bus.m_nbytes), 128'(exp_q[0].n));
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    drain();

    // Non-last word with partial keep sets a sticky err; word still packed.
    d = 32'h00CBA987;
    model_word(d, 4'h7, 1'b0, 1'b0);
    send_word(d, 4'h7, 1'b0, 1'b0);
    check("err_set", 128'(err), 128'h1);
    d = 32'h11223344;
    model_word(d, 4'hF, 1'b1, 1'b0);
    send_word(d, 4'hF, 1'b1, 1'b0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 128'(err), 128'h1);
    do_reset();
    check("err_cleared", 128'(err), 128'h0);

    // Reset mid-block discards the partial block.
    send_word(32'hCAFE0001, 4'hF, 1'b0, 1'b0);
    send_word(32'hCAFE0002, 4'hF, 1'b0, 1'b0);
    do_reset();
    check("midrst_m_valid", 128'(bus.m_valid), 128'h0);
    check("midrst_s_ready", 128'(bus.s_ready), 128'h1);
    for (int w = 0; w < 4; w++) begin
      d = 32'h50505050 + 32'(w);
      model_word(d, 4'hF, 1'(w == 3), 1'b0);
      send_word(d, 4'hF, 1'(w == 3), 1'b0);
    end
    drain();

    // Randomized legal traffic with random back-pressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      l = ($urandom_range(0, 4) == 0) || (i == 299);
      k = l ? legal[$urandom_range(0, 4)] : 4'hF;
      model_word(d, k, l, 1'($urandom_range(0, 1)));
      send_word(d, k, l, m_type);
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    bus.m_ready = 1'b1;
    drain();
    check("err_random", 128'(err), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/block_packer.md
BLOCK_PACKER -- requirements
Module: block_packer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 s_data  input  32  input stream word; stream byte order s_data[7:0] first, s_data[31:24] last.
REQ-004 s_keep  input  4  byte-valid mask of s_data; legal values 4'b0000/0001/0011/0111/1111.
REQ-005 s_last  input  1  word is final word of current message.
REQ-006 s_type  input  1  message class: 0 = associated data, 1 = plaintext/ciphertext.
REQ-007 s_valid / s_ready  input / output  1 / 1  input handshake; transfer when both high on rising edge.
REQ-008 m_block  output  128  padded block in core layout.
REQ-009 m_type  output  1  s_type of the message owning m_block.
REQ-010 m_last  output  1  m_block is final block of its message.
REQ-011 m_nbytes  output  5  count of message bytes in m_block, 0..16, excluding padding.
REQ-012 m_valid / m_ready  output / input  1 / 1  block handshake; transfer when both high.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 FSM states FILL, EMIT, EMIT_PAD; reset state FILL.
REQ-015 s_ready = 1 only in FILL; m_valid = 1 only in EMIT and EMIT_PAD.
REQ-016 Block byte j (0..7) maps to m_block[64+8j+7 : 64+8j]; byte j (8..15) maps to m_block[8(j-8)+7 : 8(j-8)]; byte 0 = first byte of block.
REQ-017 FILL: each accepted word appends popcount(s_keep) bytes at byte offset 4*word_cnt; word_cnt counts 0..3.
REQ-018 s_type is captured on the first word of a block; s_type on later words of the same block is ignored.
REQ-019 FILL -> EMIT on acceptance of the 4th word (word_cnt = 3) or of any word with s_last = 1.
REQ-020 m_valid asserts the cycle after the accepting edge; 1-cycle latency; throughput 1 block per 5 cycles when m_ready is held high.
REQ-021 Padding: when m_nbytes < 16 and m_last = 1, byte position m_nbytes holds 8'h01 and all higher bytes hold 0.
REQ-022 Non-last block: m_nbytes = 16, m_last = 0, no padding.
REQ-023 Message length a multiple of 16: the final data block is emitted with m_last = 0, followed by an EMIT_PAD block with m_nbytes = 0, byte 0 = 8'h01, remaining bytes 0, and m_last = 1.
REQ-024 s_last with s_keep = 0 as the first word of a block emits a pad-only block (m_nbytes = 0, m_last = 1).
REQ-025 EMIT with m_ready = 1: go to EMIT_PAD if a pad block is pending, else go to FILL and clear the accumulator and word_cnt.
REQ-026 EMIT_PAD with m_ready = 1: go to FILL.
REQ-027 m_block, m_type, m_last and m_nbytes hold stable while m_valid = 1 and m_ready = 0.
REQ-028 Illegal s_keep, or s_keep != 4'b1111 with s_last = 0, sets err; the word is still accepted using the popcount rule.

Reset
REQ-029 While rst_n = 0 at a clock edge: state = FILL, word_cnt = 0, accumulator = 0, pending pad flag = 0, err = 0.
REQ-030 Output values during and after reset: s_ready = 1 (after first edge), m_valid = 0, m_block = 0, m_nbytes = 0, m_last = 0, m_type = 0.
REQ-031 Reset asserted mid-block or mid-emit discards the partial block without emitting it.

Structure
REQ-032 ascon_aead128_pkg gains typedef packer_state_e {FILL, EMIT, EMIT_PAD}, constant BLOCK_BYTES = 16, and constant PAD_BYTE = 8'h01.
REQ-033 One combinational sub-module, block_pad, maps (raw bytes, nbytes) to the padded 128-bit layout of REQ-016/021.

Verification
REQ-034 Four words 03020100, 07060504, 0B0A0908, 0F0E0D0C, keep F, last on 4th word -> block 0706050403020100_0F0E0D0C0B0A0908, nbytes 16, m_last 0; then pad block 0000000000000001_0000000000000000, nbytes 0, m_last 1.
REQ-035 One word AABBCCDD, keep 0011, last -> m_block 0000000001CCDD.. i.e. byte0 = DD, byte1 = CC, byte2 = 01, rest 0; nbytes 2; m_last 1.
REQ-036 s_last with keep 0 as first word, type 1 -> single block with byte0 = 01, nbytes 0, m_last 1, m_type 1.
REQ-037 m_ready held low for 10 cycles during EMIT -> outputs stable, s_ready 0, no input accepted.
REQ-038 Non-last word with keep 0111 -> err = 1 and stays 1 until reset.
REQ-039 rst_n pulsed low after 2 words -> no block emitted; next 4-word message produces a correct block.
